// File: rtl/draw_rect_move_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA pixel-stream bundle passed between overlay stages:
//                raster counters, sync and blanking strobes, RGB444 pixel.
//                vga_in  - consumer view (all fields inputs)
//                vga_out - producer view (all fields outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_rect_move.sv
`default_nettype none
// ============================================================================
//  Module      : draw_rect_move
//  Description : Rectangle overlay stage in the vga_if pixel chain. Draws a
//                RECT_W x RECT_H rectangle (filled, or an outline BORDER
//                pixels thick) in RECT_COLOR at a runtime position. New
//                positions arrive over a valid/ready port, are clamped so
//                the rectangle stays on screen, are held in a shadow
//                register and are committed only at the rising edge of
//                vblnk, so each frame is drawn with a single position.
//                Two-cycle pipeline: stage 1 registers timing/rgb and hit
//                flag, stage 2 applies the rgb mux.
//  Ports       : clk         - pixel clock
//                rst         - asynchronous, active-high reset
//                vga_in      - upstream timing + rgb
//                vga_out     - downstream timing + rgb (2-clock latency)
//                xpos, ypos  - requested left / top edge
//                pos_valid   - request valid
//                pos_ready   - request can be accepted (no commit pending)
//                frame_start - one-cycle pulse per vblnk rising edge
//  Options     : define DRAW_RECT_MOVE_BLINK_EN to blink the rectangle with
//                a half-period of BLINK_FRAMES frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_move #(
    parameter int          HOR_PIXELS   = 800,
    parameter int          VER_PIXELS   = 600,
    parameter int          RECT_W       = 350,
    parameter int          RECT_H       = 200,
    parameter logic [11:0] RECT_COLOR   = 12'hFAF,
    parameter int          BORDER       = 0,
    parameter int          INIT_X       = (HOR_PIXELS - RECT_W) / 2,
    parameter int          INIT_Y       = (VER_PIXELS - RECT_H) / 2,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.vga_in       vga_in,
    vga_if.vga_out      vga_out,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic        frame_start
);

    // Extents minus one, at 12 bits so X + RECT_W - 1 cannot wrap.
    localparam logic [11:0] c_W_M1   = 12'(RECT_W - 1);
    localparam logic [11:0] c_H_M1   = 12'(RECT_H - 1);
    localparam logic [11:0] c_BORDER = 12'(BORDER);
    localparam logic [10:0] c_MAX_X  = 11'(HOR_PIXELS - RECT_W);
    localparam logic [10:0] c_MAX_Y  = 11'(VER_PIXELS - RECT_H);
    localparam logic [10:0] c_INIT_X = 11'(INIT_X);
    localparam logic [10:0] c_INIT_Y = 11'(INIT_Y);

    // ------------------------------------------------------------------
    // Position handshake state
    // ------------------------------------------------------------------
    logic [10:0] r_act_x;
    logic [10:0] r_act_y;
    logic [10:0] r_shadow_x;
    logic [10:0] r_shadow_y;
    logic        r_pending;
    logic        r_vblnk_prev;
    logic        r_frame_start;

    logic        w_boundary;
    logic        w_accept;
    logic [10:0] w_clamp_x;
    logic [10:0] w_clamp_y;
    logic        w_visible;

    assign w_boundary = vga_in.vblnk & ~r_vblnk_prev;
    assign w_accept   = pos_valid & ~r_pending;
    assign w_clamp_x  = (xpos > c_MAX_X) ? c_MAX_X : xpos;
    assign w_clamp_y  = (ypos > c_MAX_Y) ? c_MAX_Y : ypos;

    assign pos_ready   = ~r_pending;
    assign frame_start = r_frame_start;

    // Commit uses the pending value from before this edge, so a request
    // accepted in the boundary cycle waits for the next boundary. The two
    // branches are exclusive anyway: accept needs !pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_x       <= c_INIT_X;
            r_act_y       <= c_INIT_Y;
            r_shadow_x    <= c_INIT_X;
            r_shadow_y    <= c_INIT_Y;
            r_pending     <= 1'b0;
            r_vblnk_prev  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vblnk_prev  <= vga_in.vblnk;
            r_frame_start <= w_boundary;
            if (w_boundary && r_pending) begin
                r_act_x   <= r_shadow_x;
                r_act_y   <= r_shadow_y;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_shadow_x <= w_clamp_x;
                r_shadow_y <= w_clamp_y;
                r_pending  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional blink: visibility toggles every BLINK_FRAMES boundaries
    // ------------------------------------------------------------------
`ifdef DRAW_RECT_MOVE_BLINK_EN
    localparam logic [15:0] c_BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] r_frame_cnt;
    logic        r_visible;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
            r_visible   <= 1'b1;
        end else if (w_boundary) begin
            if (r_frame_cnt == c_BLINK_LAST) begin
                r_frame_cnt <= 16'd0;
                r_visible   <= ~r_visible;
            end else begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign w_visible = r_visible;
`else
    // Always visible; BLINK_FRAMES has no effect in this build and the
    // constant-true term only keeps the parameter referenced.
    assign w_visible = 1'b1 | (BLINK_FRAMES == 0);
`endif

    // ------------------------------------------------------------------
    // Hit test against the active position (12-bit arithmetic)
    // ------------------------------------------------------------------
    logic [11:0] w_h;
    logic [11:0] w_v;
    logic [11:0] w_x;
    logic [11:0] w_y;
    logic [11:0] w_x_end;
    logic [11:0] w_y_end;
    logic        w_in_rect;
    logic        w_edge;
    logic        w_hit;

    assign w_h     = {1'b0, vga_in.hcount};
    assign w_v     = {1'b0, vga_in.vcount};
    assign w_x     = {1'b0, r_act_x};
    assign w_y     = {1'b0, r_act_y};
    assign w_x_end = w_x + c_W_M1;
    assign w_y_end = w_y + c_H_M1;

    assign w_in_rect = (w_h >= w_x) && (w_h <= w_x_end) &&
                       (w_v >= w_y) && (w_v <= w_y_end);

    generate
        if (BORDER > 0) begin : g_outline
            // Within BORDER pixels of any edge of the rectangle.
            assign w_edge = (w_h < w_x + c_BORDER) || (w_h > w_x_end - c_BORDER) ||
                            (w_v < w_y + c_BORDER) || (w_v > w_y_end - c_BORDER);
        end else begin : g_filled
            assign w_edge = 1'b1;
        end
    endgenerate

    assign w_hit = w_in_rect & w_edge & w_visible;

    // ------------------------------------------------------------------
    // Stage 1: register timing, input rgb and hit flag
    // ------------------------------------------------------------------
    logic [10:0] r_s1_hcount;
    logic [10:0] r_s1_vcount;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_hblnk;
    logic        r_s1_vblnk;
    logic [11:0] r_s1_rgb;
    logic        r_s1_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_hcount <= 11'd0;
            r_s1_vcount <= 11'd0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= 12'd0;
            r_s1_hit    <= 1'b0;
        end else begin
            r_s1_hcount <= vga_in.hcount;
            r_s1_vcount <= vga_in.vcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_rgb    <= vga_in.rgb;
            r_s1_hit    <= w_hit;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rgb mux (blanking wins over the rectangle)
    // ------------------------------------------------------------------
    logic [10:0] r_s2_hcount;
    logic [10:0] r_s2_vcount;
    logic        r_s2_hsync;
    logic        r_s2_vsync;
    logic        r_s2_hblnk;
    logic        r_s2_vblnk;
    logic [11:0] r_s2_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_hcount <= 11'd0;
            r_s2_vcount <= 11'd0;
            r_s2_hsync  <= 1'b0;
            r_s2_vsync  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_rgb    <= 12'd0;
        end else begin
            r_s2_hcount <= r_s1_hcount;
            r_s2_vcount <= r_s1_vcount;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_vblnk  <= r_s1_vblnk;
            if (r_s1_hblnk || r_s1_vblnk) begin
                r_s2_rgb <= 12'd0;
            end else if (r_s1_hit) begin
                r_s2_rgb <= RECT_COLOR;
            end else begin
                r_s2_rgb <= r_s1_rgb;
            end
        end
    end

    assign vga_out.hcount = r_s2_hcount;
    assign vga_out.vcount = r_s2_vcount;
    assign vga_out.hsync  = r_s2_hsync;
    assign vga_out.vsync  = r_s2_vsync;
    assign vga_out.hblnk  = r_s2_hblnk;
    assign vga_out.vblnk  = r_s2_vblnk;
    assign vga_out.rgb    = r_s2_rgb;

endmodule
`default_nettype wire
